mfp_ahb_boot_loader: RTL
========================

Name: mfp_ahb_boot_loader

Overview:
- AHB-Lite write-only master sitting directly upstream of the program RAM slave.
- Consumes a byte stream from the UART receiver, assembles little-endian 32-bit words, and issues single-word AHB writes to consecutive program RAM addresses.
- Lets the host download a program image before the core is released from reset.

Parameters:
- BASE_ADDR, 32'h1FC0_0000, byte address of the first word written.
- MAX_WORDS, 16384, largest accepted image length in words.
- LEN_W, 15, width of the word counter; must satisfy 2^LEN_W > MAX_WORDS.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored while busy.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid and rx_ready are both high.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag; cleared by start.
- HADDR  out  32  AHB address.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant 4'b0011.
- HSIZE  out  3  constant 3'b010 (word).
- HTRANS  out  2  IDLE 2'b00 / NONSEQ 2'b10.
- HWDATA  out  32  write data, valid in the data phase.
- HWRITE  out  1  high in the address phase of each write.
- HREADY  in  1  slave ready; tie high for program RAM.

Behaviour:
- Reset (asynchronous, HRESETn low): state IDLE. All outputs 0 except the constants; HTRANS=IDLE, HADDR=0, HWDATA=0, rx_ready=0, busy=0, done=0, error=0.
- All outputs are registered.
- Image frame: 4-byte little-endian length L (in words), then 4*L data bytes, little-endian per word.
- IDLE:
  - rx_ready=0.
  - On start: clear error, set busy=1, idx=0, byte count=0, go to LEN.
- LEN:
  - rx_ready=1; collect 4 bytes into L.
  - On the 4th byte:
    - L > MAX_WORDS: set error, go to IDLE, busy=0.
    - L = 0: go to FINISH.
    - Otherwise: go to DATA.
- DATA:
  - rx_ready=1; shift bytes into the word buffer, byte k at bits [8k+7:8k].
  - On the 4th byte, go to ADDR with rx_ready=0 in the next cycle.
- ADDR (AHB address phase):
  - HTRANS=NONSEQ, HWRITE=1, HADDR=BASE_ADDR + 4*idx.
  - Hold until HREADY=1, then go to WDATA.
- WDATA (AHB data phase):
  - HWDATA=assembled word, HTRANS=IDLE, HWRITE=0.
  - Hold HWDATA until HREADY=1, then idx++.
  - If idx+1 == L, go to FINISH; else go to DATA.
  - HADDR keeps its last value in this state.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Per-word cost: minimum 6 cycles (4 byte cycles, 1 address-phase cycle, 1 data-phase cycle) with back-to-back rx_valid and HREADY=1.
- rx_ready is never high in ADDR, WDATA, FINISH or IDLE. Bytes offered then are not consumed.
- start while busy: ignored, no state change.
- rx_valid low mid-word: partial word is retained and the FSM waits indefinitely (no timeout).
- Address arithmetic is 32-bit and wraps modulo 2^32; no range check beyond MAX_WORDS.
- Reset asserted mid-load: immediate return to IDLE. HTRANS goes to IDLE asynchronously. Partially written RAM contents are not restored.

Optional Feature:
- Macro: MFP_BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or after the length when L=0), state CSUM accepts one byte.
  - That byte must equal the mod-256 sum of the 4 length bytes and all data bytes.
  - Match: go to FINISH (done pulse).
  - Mismatch: set error, no done pulse, go to IDLE.
  - RAM writes already performed are not undone.
- Undefined: no CSUM state; FINISH follows the last word directly and no checksum byte is consumed.

Test Plan:
- Basic load: reset, start, bytes 01 00 00 00 78 56 34 12, HREADY=1 -> one NONSEQ write: HADDR=32'h1FC0_0000, HWDATA=32'h1234_5678 in the following cycle; done pulses once; busy falls.
- Three-word load, HREADY held low 2 cycles in each phase -> HADDR sequence 1FC00000/1FC00004/1FC00008; HWDATA stable while HREADY=0; exactly 3 NONSEQ transfers.
- Length 0 -> no NONSEQ cycle; done pulse 5 cycles after start with contiguous bytes.
- Length MAX_WORDS+1 -> error=1, busy=0, no writes; a subsequent start clears error.
- rx_valid gaps and start pulses during a load -> identical RAM contents and address sequence to a gap-free load; the extra starts are ignored.
- With MFP_BOOT_LOADER_CHECKSUM_EN: image 01 00 00 00 04 03 02 01 plus checksum 0B -> done; the same image with checksum 0C -> error=1, no done pulse; reset mid-word -> HTRANS=IDLE immediately, busy=0.

Source files
------------

// File: rtl/mfp_ahb_boot_loader.sv
`timescale 1ns/1ps
// mfp_ahb_boot_loader
// ---------------------------------------------------------------------------
// AHB-Lite write-only master that downloads a program image from a UART byte
// stream into program RAM before the core is released from reset.
//
// Image frame: 4-byte little-endian word count L, then 4*L data bytes, each
// word little-endian. Word n is written as one AHB SINGLE transfer to
// BASE_ADDR + 4*n.
//
// Optional feature (macro MFP_BOOT_LOADER_CHECKSUM_EN): one extra trailing
// byte, which must equal the mod-256 sum of all length and data bytes.
// A mismatch raises error and suppresses the done pulse.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   start                  one-cycle pulse, begins a load (ignored while busy)
//   rx_data/rx_valid/rx_ready  byte stream from UART receiver
//   busy, done, error      status: load active, completion pulse, sticky error
//   HADDR..HWRITE, HREADY  AHB-Lite master interface (write-only)
// ---------------------------------------------------------------------------
module mfp_ahb_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
    parameter int unsigned MAX_WORDS = 16384,
    parameter int unsigned LEN_W     = 15
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic        HREADY
);

    localparam logic [31:0] MAX_LEN       = 32'(MAX_WORDS);
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN    = 3'd1,
        S_DATA   = 3'd2,
        S_ADDR   = 3'd3,
        S_WDATA  = 3'd4,
        S_FINISH = 3'd5
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
        , S_CSUM = 3'd6
`endif
    } state_t;

    // State entered once the image payload is complete.
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_FINISH;
`endif

    state_t             state_q, state_d;
    logic [31:0]        len_q, len_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               error_q, error_d;
    logic [31:0]        haddr_q, haddr_d;
    logic [31:0]        hwdata_q, hwdata_d;
    logic               rx_ready_q, rx_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         htrans_q, htrans_d;
    logic               hwrite_q, hwrite_d;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
`endif

    logic               accept;
    logic [31:0]        len_shift;
    logic [31:0]        word_shift;
    logic               last_word;

    // rx_ready_q is the registered handshake, so a byte is consumed exactly
    // when the upstream sees rx_ready high together with its own rx_valid.
    assign accept     = rx_valid & rx_ready_q;
    // Bytes shift in from the top: after four bytes, byte k sits at [8k+7:8k].
    assign len_shift  = {rx_data, len_q[31:8]};
    assign word_shift = {rx_data, word_q[31:8]};
    assign last_word  = ((32'(idx_q) + 32'd1) == len_q);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        word_d   = word_q;
        bcnt_d   = bcnt_q;
        idx_d    = idx_q;
        error_d  = error_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    idx_d   = '0;
                    bcnt_d  = 2'd0;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d  = len_shift;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        if (len_shift > MAX_LEN) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end else if (len_shift == 32'd0) begin
                            state_d = S_TAIL;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d = word_shift;
                    bcnt_d = bcnt_q + 2'd1;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        // Address is 32-bit and wraps; no range check here.
                        haddr_d = BASE_ADDR + (32'(idx_q) << 2);
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    hwdata_d = word_q;
                    state_d  = S_WDATA;
                end
            end
            S_WDATA: begin
                if (HREADY) begin
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = last_word ? S_TAIL : S_DATA;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == sum_q) begin
                        state_d = S_FINISH;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so each
        // registered output lines up with the state it belongs to.
        rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        busy_d     = (state_d == S_LEN) || (state_d == S_DATA) ||
                     (state_d == S_ADDR) || (state_d == S_WDATA);
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
        if (state_d == S_CSUM) begin
            rx_ready_d = 1'b1;
            busy_d     = 1'b1;
        end
`endif
        done_d   = (state_d == S_FINISH);
        htrans_d = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite_d = (state_d == S_ADDR);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            len_q      <= 32'd0;
            word_q     <= 32'd0;
            bcnt_q     <= 2'd0;
            idx_q      <= '0;
            error_q    <= 1'b0;
            haddr_q    <= 32'd0;
            hwdata_q   <= 32'd0;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            idx_q      <= idx_d;
            error_q    <= error_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
            rx_ready_q <= rx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HSIZE     = 3'b010;

endmodule
